mac_seq_ctrl: RTL

Sequencer that runs one dot product of programmable length through a single `mac` instance. It clears the accumulator, streams operand pairs over a valid/ready input, and aligns `acc` with the mac's internal operand register. It then presents the final partial sum on a valid/ready result port. It sits between the operand fetch logic and the result writeback, and is the only driver of the mac's `A`, `B`, `acc`, `format` and `reset` pins.

---
 rtl/mac_seq_pkg.sv | 16 +
 rtl/mac.sv | 47 ++++
 rtl/mac_seq_ctrl.sv | 95 +++++++++
 3 files changed

// File: rtl/mac_seq_pkg.sv
// Shared types and default widths for the mac dot-product sequencer.
package mac_seq_pkg;

    localparam int DEF_BW      = 8;
    localparam int DEF_PSUM_BW = 16;
    localparam int DEF_LEN_BW  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/mac.sv
// Multiply-accumulate unit: registers an operand pair every cycle and adds the
// product of the registered pair into psum when acc is high.
module mac #(
    parameter int bw      = 8,
    parameter int psum_bw = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [bw-1:0]      A,
    input  logic [bw-1:0]      B,
    input  logic               format,
    input  logic               acc,
    output logic [psum_bw-1:0] out
);

    // Operands are held in two's complement internally regardless of format.
    function automatic logic [bw-1:0] to_tc(input logic [bw-1:0] v, input logic sm);
        logic [bw-1:0] mag;
        mag = {1'b0, v[bw-2:0]};
        return (sm && v[bw-1]) ? -mag : v;
    endfunction

    logic signed [bw-1:0]      a_q;
    logic signed [bw-1:0]      b_q;
    logic signed [2*bw-1:0]    prod;
    logic signed [psum_bw-1:0] psum;
    logic        [psum_bw-1:0] mag_out;

    assign prod = a_q * b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q  <= '0;
            b_q  <= '0;
            psum <= '0;
        end else begin
            a_q <= to_tc(A, format);
            b_q <= to_tc(B, format);
            if (acc)
                psum <= psum + psum_bw'(prod);
        end
    end

    assign mag_out = psum[psum_bw-1] ? -psum : psum;
    assign out     = format ? {psum[psum_bw-1], mag_out[psum_bw-2:0]} : psum;

endmodule

// File: rtl/mac_seq_ctrl.sv
// Runs one programmable-length dot product through a single mac and presents
// the final partial sum on a valid/ready result port.
module mac_seq_ctrl
    import mac_seq_pkg::*;
#(
    parameter int BW      = DEF_BW,
    parameter int PSUM_BW = DEF_PSUM_BW,
    parameter int LEN_BW  = DEF_LEN_BW
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [LEN_BW-1:0]  len,
    input  logic               format,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BW-1:0]      in_a,
    input  logic [BW-1:0]      in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PSUM_BW-1:0] out_data,
    output logic               busy
);

    state_t            state, state_nx;
    logic [LEN_BW-1:0] cnt;
    logic [LEN_BW-1:0] len_q;
    logic              fmt_q;
    logic              acc_d;
    logic              hs;
    logic              mac_reset;

    assign hs   = in_valid && in_ready;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            len_q <= '0;
            fmt_q <= 1'b0;
            acc_d <= 1'b0;
        end else begin
            state <= state_nx;
            // The mac sees this pair's operands one edge later, so acc lags by one.
            acc_d <= hs;
            if (state == IDLE && start) begin
                len_q <= len;
                fmt_q <= format;
                cnt   <= '0;
            end else if (hs) begin
                cnt <= cnt + LEN_BW'(1);
            end
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mac_reset = !reset_n;
        case (state)
            IDLE:  if (start) state_nx = CLEAR;
            CLEAR: begin
                mac_reset = 1'b1;
                state_nx  = (len_q != '0) ? RUN : DONE;
            end
            RUN: begin
                in_ready = 1'b1;
                if (in_valid && cnt == len_q - LEN_BW'(1))
                    state_nx = DRAIN;
            end
            DRAIN: state_nx = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    mac #(
        .bw      (BW),
        .psum_bw (PSUM_BW)
    ) u_mac (
        .clk    (clk),
        .reset  (mac_reset),
        .A      (in_a),
        .B      (in_b),
        .format (fmt_q),
        .acc    (acc_d),
        .out    (out_data)
    );

endmodule
